// File: rtl/ext_pipe.sv
// Immediate-field extender with a one-cycle result register and a skid entry,
// so in_ready depends only on registered state.
module ext_pipe #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam int PAD_W = OUT_W - IN_W;

  // 00 sign-extend, 01 zero-extend, 10 upper-place, 11 sign-extend then <<2
  function automatic logic [OUT_W-1:0] ext_field(input logic [IN_W-1:0] d,
                                                 input logic [1:0]      m);
    logic signed [OUT_W-1:0] sx;
    logic [OUT_W-1:0]        res;
    sx = {{PAD_W{d[IN_W-1]}}, d};
    case (m)
      2'b00:   res = sx;
      2'b01:   res = {{PAD_W{1'b0}}, d};
      2'b10:   res = {d, {PAD_W{1'b0}}};
      default: res = sx <<< 2;
    endcase
    return res;
  endfunction

  logic             main_vld_q,  main_vld_d;
  logic [OUT_W-1:0] main_data_q, main_data_d;
  logic [1:0]       main_mode_q, main_mode_d;
  logic             skid_vld_q,  skid_vld_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [1:0]       skid_mode_q, skid_mode_d;

  logic             push;
  logic             pop;
  logic [OUT_W-1:0] ext_in;

  assign in_ready  = ~skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_data_q;
  assign out_mode  = main_mode_q;

  assign push   = in_valid & in_ready;
  assign pop    = main_vld_q & out_ready;
  assign ext_in = ext_field(in_data, in_mode);

  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    main_mode_d = main_mode_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_mode_d = skid_mode_q;
    if (skid_vld_q && pop) begin
      // in_ready is low here, so the skid entry is the only candidate for main
      main_data_d = skid_data_q;
      main_mode_d = skid_mode_q;
      skid_vld_d  = 1'b0;
    end else if (push && (!main_vld_q || pop)) begin
      main_vld_d  = 1'b1;
      main_data_d = ext_in;
      main_mode_d = in_mode;
    end else if (push) begin
      skid_vld_d  = 1'b1;
      skid_data_d = ext_in;
      skid_mode_d = in_mode;
    end else if (pop) begin
      main_vld_d  = 1'b0;
    end
  end

  // Output / skid register stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      main_mode_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_mode_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      main_mode_q <= main_mode_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_mode_q <= skid_mode_d;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed and random stimulus for ext_pipe with a queue scoreboard and an
// occupancy model checked on every falling edge.
module tb_ext_pipe;

  localparam int IN_W  = 17;
  localparam int OUT_W = 32;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mode (out_mode)
  );

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [1:0]       m;
  } exp_t;

  exp_t             sb[$];
  logic [OUT_W-1:0] cur_exp;
  int               checks;
  int               errors;
  int               pop_cnt;
  logic             hold_vld;
  logic [OUT_W-1:0] hold_data;
  logic [1:0]       hold_mode;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] d, input logic [1:0] m);
    longint sv;
    logic [OUT_W-1:0] r;
    sv = d[IN_W-1] ? longint'(d) - 131072 : longint'(d);
    case (m)
      2'd0:    r = sv[31:0];
      2'd1:    r = {15'b0, d};
      2'd2:    r = {d, 15'b0};
      default: begin sv = sv * 4; r = sv[31:0]; end
    endcase
    return r;
  endfunction

  // Falling-edge monitor: occupancy, scoreboard pop/compare, hold stability, push
  always @(negedge clock) begin
    if (!reset_n) begin
      hold_vld = 1'b0;
    end else begin
      checks++;
      assert (out_valid === (sb.size() > 0)) else begin
        errors++;
        $error("FAIL occ_out_valid got %0b want %0b", out_valid, sb.size() > 0);
      end
      checks++;
      assert (in_ready === (sb.size() < 2)) else begin
        errors++;
        $error("FAIL occ_in_ready got %0b want %0b", in_ready, sb.size() < 2);
      end
      if (hold_vld && out_valid) begin
        checks++;
        assert (out_data === hold_data && out_mode === hold_mode) else begin
          errors++;
          $error("FAIL hold_stable got %h/%0d want %h/%0d", out_data, out_mode, hold_data, hold_mode);
        end
      end
      hold_vld  = out_valid && !out_ready;
      hold_data = out_data;
      hold_mode = out_mode;
      if (out_valid && out_ready) begin
        pop_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $error("FAIL sb_underflow got out_data %h want no result", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          assert (out_data === e.d && out_mode === e.m) else begin
            errors++;
            $error("FAIL result got %h/%0d want %h/%0d", out_data, out_mode, e.d, e.m);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back({cur_exp, in_mode});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic [1:0] m, input logic [OUT_W-1:0] e);
    in_data  = d;
    in_mode  = m;
    cur_exp  = e;
    in_valid = 1'b1;
    step();
  endtask

  task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops_before;
    logic [IN_W-1:0] rd;
    logic [1:0]      rm;
    checks = 0; errors = 0; pop_cnt = 0; hold_vld = 1'b0;
    hold_data = '0; hold_mode = '0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0;
    out_ready = 1'b0; cur_exp = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_mode",  32'(out_mode),  32'd0);
    step(); step();

    // mode sweep, first push on the first edge after release
    reset_n = 1'b1; out_ready = 1'b1;
    send(17'h10000, 2'd0, 32'hFFFF0000);
    send(17'h10000, 2'd1, 32'h00010000);
    send(17'h10000, 2'd2, 32'h80000000);
    send(17'h10000, 2'd3, 32'hFFFC0000);
    send(17'h0FFFF, 2'd0, 32'h0000FFFF);
    send(17'h0FFFF, 2'd3, 32'h0003FFFC);
    send(17'h0FFFF, 2'd2, 32'h7FFF8000);
    in_valid = 1'b0;
    step(); step();

    // backpressure, then simultaneous pop with a full skid
    out_ready = 1'b0;
    send(17'h00005, 2'd0, model(17'h00005, 2'd0));
    send(17'h1FFFE, 2'd3, model(17'h1FFFE, 2'd3));
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    send(17'h12345, 2'd2, model(17'h12345, 2'd2));
    chk("bp_c_blocked", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b1;
    step();
    chk("simul_in_ready", 32'(in_ready), 32'd1);
    chk("simul_b_in_main", out_data, model(17'h1FFFE, 2'd3));
    step();
    in_valid = 1'b0;
    step(); step();

    // streaming at full rate
    pops_before = pop_cnt;
    for (int i = 0; i < 100; i++) begin
      rd = IN_W'($urandom);
      rm = 2'($urandom_range(0, 3));
      send(rd, rm, model(rd, rm));
    end
    in_valid = 1'b0;
    step(); step();
    chk("stream_count", 32'(pop_cnt - pops_before), 32'd100);

    // asynchronous reset with both entries full
    out_ready = 1'b0;
    send(17'h0AAAA, 2'd1, model(17'h0AAAA, 2'd1));
    send(17'h15555, 2'd0, model(17'h15555, 2'd0));
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_out_data",  out_data,       32'd0);
    sb.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
